// File: rtl/ram_sync_ctrl.sv
// ram_sync_ctrl: single-clock scratch RAM with valid/ready requests, fixed-latency reads and a clear sweep.
// Optional feature macro: RAM_SYNC_CTRL_PARITY_EN (even parity bit per word, err_inject / rsp_perr ports).
`default_nettype none

module ram_sync_ctrl #(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 6,
  parameter int READ_LAT   = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clear,
  output logic              init_busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
`ifdef RAM_SYNC_CTRL_PARITY_EN
  ,
  input  logic              err_inject,
  output logic              rsp_perr
`endif
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef RAM_SYNC_CTRL_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_busy;
  logic                r_boot;
  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic                w_accept;
  logic                w_rd_fire;
  logic [WORD_W-1:0]   w_wr_word;
  logic [WORD_W-1:0]   w_rd_word;
  logic                w_out_fire;
  logic [WORD_W-1:0]   w_out_word;

  // r_boot holds off requests until the post-reset sweep has been launched.
  assign req_ready = rst_n && (r_state == S_IDLE) && !clear && !r_boot;
  assign w_accept  = req_valid && req_ready;
  assign w_rd_fire = w_accept && !req_we;
  assign w_rd_word = r_mem[req_addr];
  assign init_busy = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

`ifdef RAM_SYNC_CTRL_PARITY_EN
  assign w_wr_word = {(^req_wdata) ^ err_inject, req_wdata};
`else
  assign w_wr_word = req_wdata;
`endif

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_accept && req_we) begin
      r_mem[req_addr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_boot  <= (INIT_CLEAR != 0);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear || r_boot) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_boot  <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {ADDR_W{1'b1}}) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_p_valid;
      logic [WORD_W-1:0] r_p_word;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_p_valid <= 1'b0;
          r_p_word  <= '0;
        end else begin
          r_p_valid <= w_rd_fire;
          if (w_rd_fire) begin
            r_p_word <= w_rd_word;
          end
        end
      end
      assign w_out_fire = r_p_valid;
      assign w_out_word = r_p_word;
    end else begin : g_lat1
      assign w_out_fire = w_rd_fire;
      assign w_out_word = w_rd_word;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_out_fire;
      if (w_out_fire) begin
        r_rsp_rdata <= w_out_word[DATA_W-1:0];
      end
    end
  end

`ifdef RAM_SYNC_CTRL_PARITY_EN
  logic r_rsp_perr;
  assign rsp_perr = r_rsp_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_perr <= 1'b0;
    end else if (w_out_fire) begin
      r_rsp_perr <= ^w_out_word;
    end
  end
`endif

endmodule

`default_nettype wire
